// File: rtl/pong_pkg.sv
// ============================================================================
// pong_pkg : shared constants and types for the Pong input sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

package pong_pkg;

  localparam int CLK_HZ           = 25_000_000;
  // 10 ms of stable level before a button change is accepted
  localparam int DEBOUNCE_DEFAULT = CLK_HZ / 100;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// button_debounce : two-flop synchroniser plus hold-time debouncer
// Revision : 1.0
// ============================================================================
`default_nettype none

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic stable
);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      // any return to the accepted level restarts the hold window
      if (sync_2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync_2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pong_input_sequencer.sv
// ============================================================================
// pong_input_sequencer : per-frame paddle sampling and update handshake
// Revision : 1.0
// ============================================================================
`default_nettype none

module pong_input_sequencer
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 18
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       VBLANK,
  input  logic       UPDATE_ACK,
  output logic       UPDATE_REQ,
  output logic [1:0] DIR,
  output logic [7:0] FRAME_CNT,
  output logic       OVERRUN
);

  logic       up_stable;
  logic       down_stable;
  logic       vb_d;
  logic       frame_edge;
  logic [1:0] dir_decoded;
  seq_state_t state;
  seq_state_t next_state;
  logic       capture;
  logic       overrun_set;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce_up (
    .clk     (CLK_25MHZ),
    .rst     (RESET),
    .btn_raw (BTN_UP),
    .stable  (up_stable)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce_down (
    .clk     (CLK_25MHZ),
    .rst     (RESET),
    .btn_raw (BTN_DOWN),
    .stable  (down_stable)
  );

  assign frame_edge = VBLANK & ~vb_d;

  always_comb begin
    dir_decoded = DIR_NONE;
    case ({up_stable, down_stable})
      2'b10:   dir_decoded = DIR_UP;
      2'b01:   dir_decoded = DIR_DOWN;
      default: dir_decoded = DIR_NONE;
    endcase
  end

  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (frame_edge) begin
          next_state = REQ;
          capture    = 1'b1;
        end
      end
      REQ: begin
        // ack and edge together hand over straight to the next frame
        if (frame_edge && UPDATE_ACK) begin
          capture = 1'b1;
        end else if (frame_edge) begin
          overrun_set = 1'b1;
        end else if (UPDATE_ACK) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      state     <= IDLE;
      vb_d      <= 1'b1;
      DIR       <= DIR_NONE;
      FRAME_CNT <= 8'd0;
      OVERRUN   <= 1'b0;
    end else begin
      state <= next_state;
      vb_d  <= VBLANK;
      if (capture) begin
        DIR       <= dir_decoded;
        FRAME_CNT <= FRAME_CNT + 8'd1;
      end
      if (overrun_set) begin
        OVERRUN <= 1'b1;
      end
    end
  end

  assign UPDATE_REQ = (state == REQ);

endmodule

`default_nettype wire

// File: tb/tb_pong_input_sequencer.sv
// ============================================================================
// tb_pong_input_sequencer : directed self-checking bench for the sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pong_input_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       vblank;
  logic       ack;
  logic       req;
  logic [1:0] dir;
  logic [7:0] frame_cnt;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  pong_input_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .CLK_25MHZ  (clk),
    .RESET      (rst),
    .BTN_UP     (btn_up),
    .BTN_DOWN   (btn_down),
    .VBLANK     (vblank),
    .UPDATE_ACK (ack),
    .UPDATE_REQ (req),
    .DIR        (dir),
    .FRAME_CNT  (frame_cnt),
    .OVERRUN    (overrun)
  );

  always #20 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // low then high on VBLANK; outputs reflect the edge when this returns
  task automatic frame_edge();
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; vblank = 1'b1; ack = 1'b0;
    tick(3);
    check_eq("rst_req", req, 0);
    check_eq("rst_dir", dir, 0);
    check_eq("rst_cnt", frame_cnt, 0);
    check_eq("rst_ovr", overrun, 0);

    rst = 1'b0;
    tick(5);
    check_eq("no_edge_req", req, 0);
    check_eq("no_edge_cnt", frame_cnt, 0);

    // 3-cycle bounce on up must not be accepted
    btn_up = 1'b1; tick(3); btn_up = 1'b0; tick(10);
    frame_edge();
    check_eq("bounce_req", req, 1);
    check_eq("bounce_dir", dir, 2'b00);
    check_eq("bounce_cnt", frame_cnt, 1);
    pulse_ack();
    check_eq("ack_req", req, 0);
    ack = 1'b1; tick(); ack = 1'b0;
    check_eq("idle_ack_ignored", req, 0);

    btn_up = 1'b1; tick(10);
    frame_edge();
    check_eq("up_req", req, 1);
    check_eq("up_dir", dir, 2'b01);
    check_eq("up_cnt", frame_cnt, 2);
    pulse_ack();
    check_eq("up_ack", req, 0);

    btn_down = 1'b1; tick(10);
    frame_edge();
    check_eq("both_dir", dir, 2'b00);
    check_eq("both_cnt", frame_cnt, 3);
    pulse_ack();

    btn_up = 1'b0; tick(10);
    frame_edge();
    check_eq("down_dir", dir, 2'b10);
    check_eq("down_cnt", frame_cnt, 4);

    // button change while request is outstanding leaves DIR frozen
    btn_up = 1'b1; btn_down = 1'b0; tick(10);
    check_eq("frozen_dir", dir, 2'b10);
    check_eq("held_req", req, 1);

    vblank = 1'b0; tick();
    vblank = 1'b1; ack = 1'b1; tick(); ack = 1'b0;
    check_eq("coinc_req", req, 1);
    check_eq("coinc_cnt", frame_cnt, 5);
    check_eq("coinc_dir", dir, 2'b01);
    check_eq("coinc_ovr", overrun, 0);
    pulse_ack();
    check_eq("coinc_ack", req, 0);

    frame_edge();
    check_eq("pre_ovr_cnt", frame_cnt, 6);
    btn_up = 1'b0; tick(10);
    frame_edge();
    check_eq("ovr_flag", overrun, 1);
    check_eq("ovr_cnt", frame_cnt, 6);
    check_eq("ovr_dir", dir, 2'b01);
    check_eq("ovr_req", req, 1);
    pulse_ack();
    check_eq("ovr_ack_req", req, 0);
    check_eq("ovr_sticky", overrun, 1);

    for (int i = 0; i < 250; i++) begin
      frame_edge();
      pulse_ack();
    end
    check_eq("wrap_cnt", frame_cnt, 0);
    check_eq("wrap_ovr", overrun, 1);

    frame_edge();
    check_eq("post_wrap_cnt", frame_cnt, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("midreq_rst_req", req, 0);
    check_eq("midreq_rst_cnt", frame_cnt, 0);
    check_eq("midreq_rst_ovr", overrun, 0);
    check_eq("midreq_rst_dir", dir, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
